// File: rtl/rv64_pkg.sv
// Shared RV64 execute-stage definitions.
// Holds the datapath width, shift-amount widths and the state type used by
// the iterative shift units (sll now, sra/srl later).
package rv64_pkg;

    localparam int XLEN     = 64;
    localparam int SHAMT_W  = $clog2(XLEN);
    localparam int WSHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_t;

endpackage

// File: rtl/sll_step.sv
// One iteration of the left shifter: shifts the working value left by
// 0..STEP bits with zero fill. Bits pushed past the MSB are discarded.
// Ports:
//   dataIn   value before this iteration
//   shiftBy  bits to shift this iteration (0..STEP)
//   dataOut  shifted value
module sll_step #(
    parameter int N    = 64,
    parameter int STEP = 8
) (
    input  logic [N-1:0]                dataIn,
    input  logic [$clog2(STEP+1)-1:0]   shiftBy,
    output logic [N-1:0]                dataOut
);

    assign dataOut = dataIn << shiftBy;

endmodule

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter for SLL/SLLI and SLLW/SLLIW.
// Shifts at most STEP bits per cycle; valid/ready on both sides.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand handshake (ready only in IDLE)
//   data_in, amount      value and shift amount
//   word_op              1 = 32-bit op, result sign-extended from bit 31
//   out_valid/out_ready  result handshake (valid only in DONE)
//   data_out             result, zero outside DONE
//   busy                 high in SHIFT or DONE
//
// state | meaning
// IDLE  | waiting for an operand
// SHIFT | shifting up to STEP bits per cycle
// DONE  | result presented, waiting for out_ready
module sll_iter
    import rv64_pkg::*;
#(
    parameter int N    = XLEN,
    parameter int STEP = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          data_in,
    input  logic [$clog2(N)-1:0]  amount,
    input  logic                  word_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          data_out,
    output logic                  busy
);

    localparam int SW = $clog2(N);
    localparam int CW = $clog2(STEP + 1);
    localparam logic [SW:0] STEP_LIM = (SW + 1)'(STEP);

    shift_state_t state, nextState;

    logic [N-1:0]  work;
    logic [SW-1:0] remaining;
    logic          wordOp;

    logic [SW-1:0] loadRem;
    logic [CW-1:0] stepAmt;
    logic [SW-1:0] remNext;
    logic [N-1:0]  stepOut;
    logic [N-1:0]  resultFmt;
    logic          accept;

    // Word ops only honour the low five amount bits.
    assign loadRem = word_op ? SW'(amount[WSHAMT_W-1:0]) : amount;

    always_comb begin
        if ({1'b0, remaining} >= STEP_LIM) begin
            stepAmt = CW'(STEP);
        end else begin
            stepAmt = CW'(remaining);
        end
    end

    // stepAmt never exceeds remaining, so this cannot underflow.
    assign remNext = remaining - SW'(stepAmt);

    sll_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .dataIn  (work),
        .shiftBy (stepAmt),
        .dataOut (stepOut)
    );

    // Upper bits of work are don't-care for word ops; the signed cast
    // rebuilds them from bit 31.
    assign resultFmt = wordOp ? N'($signed(work[31:0])) : work;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        data_out  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    nextState = (loadRem == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (remNext == '0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                data_out  = resultFmt;
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            remaining <= '0;
            wordOp    <= 1'b0;
        end else if (accept) begin
            work      <= data_in;
            remaining <= loadRem;
            wordOp    <= word_op;
        end else if (state == SHIFT) begin
            work      <= stepOut;
            remaining <= remNext;
        end
    end

endmodule

// File: tb/tb_sll_iter.sv
module tb_sll_iter;

    localparam int N    = 64;
    localparam int STEP = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  data_in;
    logic [5:0]    amount;
    logic          word_op;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  data_out;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;

    sll_iter #(.N(N), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .amount    (amount),
        .word_op   (word_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: architectural SLL / SLLW result.
    function automatic logic [63:0] refShift(input logic [63:0] d, input int amt, input bit w);
        logic [31:0] lo;
        if (w) begin
            lo = d[31:0] << (amt % 32);
            return {{32{lo[31]}}, lo};
        end
        return d << amt;
    endfunction

    // Reference: cycles from handshake to first out_valid.
    function automatic int refLat(input int amt, input bit w);
        int k;
        k = w ? (amt % 32) : amt;
        if (k == 0) return 1;
        return 1 + (k + STEP - 1) / STEP;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op, waits for the result, checks value/latency, then
    // drains it after holdCycles of backpressure.
    task automatic runOp(input string tag, input logic [63:0] d, input int amt,
                         input bit w, input int holdCycles);
        int n;
        logic [63:0] expData;
        expData = refShift(d, amt, w);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        data_in  = d;
        amount   = 6'(amt);
        word_op  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = 64'($urandom());
        amount   = 6'($urandom_range(0, 63));
        n = 1;
        while (!out_valid && n < 40) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(refLat(amt, w)));
        check({tag, " data"}, data_out, expData);
        for (int i = 0; i < holdCycles; i++) begin
            tick();
            check({tag, " hold valid"}, 64'(out_valid), 64'd1);
            check({tag, " hold data"}, data_out, expData);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        amount    = '0;
        word_op   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset", {in_ready, out_valid, busy}, 64'b100);
        check("reset data", data_out, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases
        runOp("sra mirror", 64'h0000_0000_0000_8100, 4, 1'b0, 0);
        runOp("max shift", 64'h0000_0000_0000_0003, 63, 1'b0, 0);
        runOp("word sext", 64'h1234_5678_4000_0001, 1, 1'b1, 0);
        runOp("word mask", 64'h0000_0000_0000_0001, 40, 1'b1, 0);
        runOp("step edge", 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b0, 0);
        runOp("step edge9", 64'h0123_4567_89AB_CDEF, 9, 1'b0, 0);

        // Zero shift with backpressure; in_valid held during DONE must be ignored.
        data_in  = 64'hDEAD_BEEF_0000_0001;
        amount   = 6'd0;
        word_op  = 1'b0;
        in_valid = 1'b1;
        tick();
        data_in  = 64'h5555_5555_5555_5555;
        amount   = 6'd3;
        for (int i = 0; i < 5; i++) begin
            check("bp valid", 64'(out_valid), 64'd1);
            check("bp in_ready", 64'(in_ready), 64'd0);
            check("bp data", data_out, 64'hDEAD_BEEF_0000_0001);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp idle", {in_ready, out_valid, busy}, 64'b100);

        // Reset mid-SHIFT
        data_in  = 64'h0000_0000_0000_0001;
        amount   = 6'd50;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst", {in_ready, out_valid, busy}, 64'b100);
        check("async rst data", data_out, 64'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) n++;
            tick();
        end
        check("no spurious valid", 64'(n), 64'd0);
        runOp("post reset", 64'd1, 1, 1'b0, 0);

        // Reset mid-DONE
        data_in  = 64'h0000_0000_0000_00FF;
        amount   = 6'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pre rst done", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst in done", {in_ready, out_valid, busy}, 64'b100);
        tick();
        rst_n = 1'b1;
        tick();
        check("after done rst", 64'(out_valid), 64'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            runOp($sformatf("rand%0d", i), {$urandom(), $urandom()},
                  int'($urandom_range(0, 63)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sll_iter.md
Name: sll_iter

Overview:
- Multi-cycle logical left shifter for the RV64 execute stage; the left-direction counterpart of the combinational arithmetic right shifter `sra`.
- Implements SLL/SLLI (64-bit) and SLLW/SLLIW (32-bit op, result sign-extended to 64).
- Shifts at most STEP bits per cycle, trading latency for area.
- Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
- N, 64, datapath width (XLEN); power of two, at least 32.
- STEP, 8, maximum bits shifted per cycle; power of two, 1..N.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand; high only in IDLE.
- data_in  in  N  value to shift.
- amount  in  $clog2(N)  shift amount.
- word_op  in  1  1 = SLLW semantics.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- data_out  out  N  shifted result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, in_ready=1, out_valid=0, busy=0, data_out=0, internal remaining count=0.
- States: IDLE, SHIFT, DONE.
- IDLE: accept when in_valid && in_ready at a rising edge.
  - Latch data_in into the working register.
  - Latch word_op.
  - remaining = word_op ? {0, amount[4:0]} : amount. For word ops, amount[5] is ignored per the ISA.
  - Next state: DONE if remaining==0, else SHIFT.
  - Inputs are ignored while in_ready=0.
- SHIFT, each edge:
  - s = min(remaining, STEP).
  - work <= work << s, zero fill.
  - remaining <= remaining - s.
  - Go to DONE when remaining - s == 0.
- DONE:
  - out_valid=1.
  - data_out = word_op ? {{(N-32){work[31]}}, work[31:0]} : work.
  - data_out stays stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE.
  - No new operand is accepted in the same cycle (in_ready is 0 in DONE); back-to-back throughput is one op per latency+1 cycles.
- Latency, for a handshake in cycle c:
  - out_valid is first high in cycle c+1 when the effective amount k=0.
  - Otherwise out_valid is first high in cycle c+1+ceil(k/STEP).
  - With N=64, STEP=8, k=63: cycle c+9.
- Width rules:
  - Bits shifted past the MSB are discarded.
  - Bits above bit 31 in word ops may be garbage internally; only the sign-extended output is architecturally visible.
- Reset asserted mid-SHIFT or mid-DONE:
  - Outputs return to reset values immediately (asynchronous).
  - The in-flight result is lost; no spurious out_valid after release.
- out_ready high outside DONE has no effect.
- in_valid held high across DONE is not accepted until the cycle after returning to IDLE.

Decomposition:
- Shared package rv64_pkg holds:
  - XLEN=64
  - SHAMT_W=$clog2(XLEN)
  - WSHAMT_W=5
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} shift_state_t, shared with the planned iterative sra/srl units.
- One natural sub-module, sll_step: combinational shift of the working register by 0..STEP bits, zero fill, instantiated once. The FSM, counter and sign-extension stay in sll_iter.

Test Plan:
- Mirror of the existing sra check: data_in=64'h0000_0000_0000_8100, amount=4, word_op=0 -> data_out=64'h0000_0000_0008_1000, out_valid first high in cycle c+2.
- Max shift: data_in=64'h0000_0000_0000_0003, amount=63 -> data_out=64'h8000_0000_0000_0000, out_valid first high in cycle c+9, busy high cycles c+1..c+9.
- Word op: data_in=64'h1234_5678_4000_0001, amount=1, word_op=1 -> 64'hFFFF_FFFF_8000_0002. Then amount=40 (masked to 8), data_in=64'h0000_0000_0000_0001, word_op=1 -> 64'h0000_0000_0000_0100.
- Zero shift and backpressure: amount=0, data_in=64'hDEAD_BEEF_0000_0001, out_ready=0 for 5 cycles -> out_valid held high and data_out stable for all 5 cycles; in_ready=0 throughout; IDLE one cycle after out_ready rises.
- Reset mid-operation: start amount=50, drop rst_n two cycles after the handshake -> in_ready=1, out_valid=0, busy=0, data_out=0 immediately. After release, no out_valid until a new handshake; a new op amount=1, data_in=1 returns 2.
